step_sequencer: RTL and testbench

- Phase controller for the 16-bit multi-cycle core on the FPGA board.
- Sequences one instruction through FETCH/DECODE/EXEC/WB, either once per centre-button release (step mode) or at a fixed rate (run mode).
- Emits the load and write enables for the IR, PC, register file and data memory.
- Drives the display-source select and the halted/busy status LEDs.

---
 rtl/step_seq_pkg.sv | 16 +
 rtl/btn_edge_detect.sv | 20 ++
 rtl/step_sequencer.sv | 109 ++++++++++
 tb/tb_step_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/step_seq_pkg.sv
// Shared types and defaults for the instruction phase sequencer.
package step_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_e;

  localparam int unsigned RUN_DIV_DEFAULT = 25000000;
  localparam int unsigned CNT_W_DEFAULT   = 16;

endpackage

// File: rtl/btn_edge_detect.sv
// Registers a debounced button level and emits single-cycle press/release pulses.
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic press_o,
  output logic release_o
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level_i;
  end

  assign press_o   = level_i & ~level_q;
  assign release_o = ~level_i & level_q;

endmodule

// File: rtl/step_sequencer.sv
// FETCH/DECODE/EXEC/WB phase controller, stepped by button release or a run-mode rate counter.
// Optional run-mode PC breakpoint enabled by defining STEP_SEQ_BREAKPOINT_EN.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int unsigned RUN_DIV = RUN_DIV_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btnc_db,
  input  logic             run_mode,
  input  logic             dec_reg_write,
  input  logic             dec_mem_write,
  input  logic             dec_halt,
  output logic             ir_load,
  output logic             pc_en,
  output logic             reg_write_en,
  output logic             mem_write_en,
  output logic             disp_sel,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
`ifdef STEP_SEQ_BREAKPOINT_EN
  ,
  input  logic [15:0]      pc,
  input  logic [15:0]      bp_addr,
  input  logic             bp_valid,
  output logic             bp_hit
`endif
);

  localparam int unsigned RW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [RW-1:0] RATE_LAST = RW'(RUN_DIV - 1);

  state_e           state_q;
  logic [RW-1:0]    rate_q;
  logic [CNT_W-1:0] count_q;
  logic             btn_release;

  btn_edge_detect u_btnc (
    .clk       (clk),
    .rst_n     (reset),
    .level_i   (btnc_db),
    .press_o   (),
    .release_o (btn_release)
  );

`ifdef STEP_SEQ_BREAKPOINT_EN
  logic bp_hit_q;
  logic bp_match;
  assign bp_match = bp_valid && (pc == bp_addr);
  assign bp_hit   = bp_hit_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rate_q   <= '0;
      count_q  <= '0;
`ifdef STEP_SEQ_BREAKPOINT_EN
      bp_hit_q <= 1'b0;
`endif
    end else begin
      // Rate counter only advances while idling in run mode; every other path clears it.
      rate_q <= '0;
      case (state_q)
        IDLE: begin
          if (run_mode) begin
            if (rate_q == RATE_LAST) begin
`ifdef STEP_SEQ_BREAKPOINT_EN
              if (bp_hit_q || bp_match) bp_hit_q <= 1'b1;
              else                      state_q  <= FETCH;
`else
              state_q <= FETCH;
`endif
            end else begin
              rate_q <= rate_q + 1'b1;
            end
          end else if (btn_release) begin
            state_q <= FETCH;
          end
        end
        FETCH:   state_q <= DECODE;
        DECODE:  state_q <= dec_halt ? HALTED : EXEC;
        EXEC:    state_q <= WB;
        WB: begin
          count_q <= count_q + 1'b1;
          state_q <= IDLE;
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
`ifdef STEP_SEQ_BREAKPOINT_EN
      if (!run_mode) bp_hit_q <= 1'b0;
`endif
    end
  end

  assign ir_load      = (state_q == FETCH);
  assign mem_write_en = (state_q == EXEC) && dec_mem_write;
  assign reg_write_en = (state_q == WB) && dec_reg_write;
  assign pc_en        = (state_q == WB);
  assign busy         = (state_q inside {FETCH, DECODE, EXEC, WB});
  assign halted       = (state_q == HALTED);
  assign disp_sel     = btnc_db;
  assign step_count   = count_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer (small RUN_DIV and CNT_W for short runs).
module tb_step_sequencer;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset, btnc_db, run_mode;
  logic          dec_reg_write, dec_mem_write, dec_halt;
  logic          ir_load, pc_en, reg_write_en, mem_write_en;
  logic          disp_sel, busy, halted;
  logic [CW-1:0] step_count;
`ifdef STEP_SEQ_BREAKPOINT_EN
  logic [15:0]   pc, bp_addr;
  logic          bp_valid, bp_hit;
`endif

  step_sequencer #(
    .RUN_DIV (4),
    .CNT_W   (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btnc_db       (btnc_db),
    .run_mode      (run_mode),
    .dec_reg_write (dec_reg_write),
    .dec_mem_write (dec_mem_write),
    .dec_halt      (dec_halt),
    .ir_load       (ir_load),
    .pc_en         (pc_en),
    .reg_write_en  (reg_write_en),
    .mem_write_en  (mem_write_en),
    .disp_sel      (disp_sel),
    .busy          (busy),
    .halted        (halted),
    .step_count    (step_count)
`ifdef STEP_SEQ_BREAKPOINT_EN
    ,
    .pc            (pc),
    .bp_addr       (bp_addr),
    .bp_valid      (bp_valid),
    .bp_hit        (bp_hit)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned ir_cnt   = 0;
  int unsigned pc_cnt   = 0;

  always @(posedge clk) begin
    if (ir_load) ir_cnt++;
    if (pc_en)   pc_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at a negedge with the release edge active for the coming posedge.
  task automatic press_release();
    btnc_db = 1'b1;
    cyc(2);
    btnc_db = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]    exp_tbl [5];
    int unsigned   base_ir, base_pc;
    logic [CW-1:0] exp_cnt;
    bit            reached;

    exp_tbl = '{5'b10001, 5'b00001, 5'b01001, 5'b00111, 5'b00000};
    reset = 1'b0; btnc_db = 1'b1; run_mode = 1'b0;
    dec_reg_write = 1'b0; dec_mem_write = 1'b0; dec_halt = 1'b0;
`ifdef STEP_SEQ_BREAKPOINT_EN
    pc = '0; bp_addr = '0; bp_valid = 1'b0;
`endif

    // Reset with button held
    cyc(2);
    check_eq("reset_outputs", {ir_load, pc_en, reg_write_en, mem_write_en, busy, halted}, 0);
    check_eq("reset_disp_sel", disp_sel, 1);
    check_eq("reset_count", step_count, 0);
`ifdef STEP_SEQ_BREAKPOINT_EN
    check_eq("reset_bp_hit", bp_hit, 0);
`endif
    btnc_db = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(2);
    check_eq("post_reset_busy", busy, 0);
    check_eq("post_reset_disp", disp_sel, 0);

    // Single step with both writes; a held button must not start anything
    dec_reg_write = 1'b1; dec_mem_write = 1'b1;
    btnc_db = 1'b1;
    cyc(4);
    check_eq("held_no_step", busy, 0);
    check_eq("held_disp_sel", disp_sel, 1);
    btnc_db = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check_eq($sformatf("step_phase%0d", k),
               {ir_load, mem_write_en, reg_write_en, pc_en, busy}, 32'(exp_tbl[k]));
    end
    check_eq("step_count_1", step_count, 1);

    // Step with no writes: only pc_en in WB
    dec_reg_write = 1'b0; dec_mem_write = 1'b0;
    press_release();
    cyc(3);
    check_eq("nowrite_exec", {mem_write_en, busy}, 2'b01);
    cyc(1);
    check_eq("nowrite_wb", {mem_write_en, reg_write_en, pc_en}, 3'b001);
    cyc(1);
    check_eq("step_count_2", step_count, 2);

    // Run mode, RUN_DIV=4: FETCH every 8 cycles starting 4 cycles in
    base_ir = ir_cnt;
    run_mode = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (i == 4)  check_eq("run_first_fetch", ir_load, 1);
      if (i == 8)  check_eq("run_idle_gap", busy, 0);
      if (i == 12) check_eq("run_second_fetch", ir_load, 1);
    end
    run_mode = 1'b0;
    cyc(2);
    check_eq("run_ir_pulses", ir_cnt - base_ir, 5);
    check_eq("run_step_count", step_count, 7);
    exp_cnt = 4'd7;

`ifdef STEP_SEQ_BREAKPOINT_EN
    // Breakpoint suppresses auto-steps until run_mode is sampled low
    base_ir = ir_cnt;
    bp_valid = 1'b1; pc = 16'h0010; bp_addr = 16'h0010;
    run_mode = 1'b1;
    cyc(10);
    check_eq("bp_hit_set", bp_hit, 1);
    check_eq("bp_no_fetch", ir_cnt - base_ir, 0);
    run_mode = 1'b0; pc = 16'h0011;
    cyc(1);
    check_eq("bp_hit_clear", bp_hit, 0);
    base_ir = ir_cnt;
    run_mode = 1'b1;
    cyc(16);
    run_mode = 1'b0;
    cyc(2);
    check_eq("bp_resume_fetch", ir_cnt - base_ir, 2);
    check_eq("bp_resume_hit", bp_hit, 0);
    bp_valid = 1'b0;
    exp_cnt = exp_cnt + 4'd2;
`endif
    check_eq("count_before_wrap", step_count, 32'(exp_cnt));

    // Advance to all-ones in run mode, stopping as soon as WB retires it
    run_mode = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (step_count == '1) begin
        reached = 1'b1;
        break;
      end
    end
    run_mode = 1'b0;
    check_eq("wrap_preload", reached, 1);

    // One more step wraps; a second press/release while busy is dropped
    base_ir = ir_cnt;
    dec_reg_write = 1'b1;
    press_release();
    cyc(1);
    btnc_db = 1'b1;
    cyc(1);
    btnc_db = 1'b0;
    cyc(6);
    check_eq("wrap_count", step_count, 0);
    check_eq("drop_ir_pulses", ir_cnt - base_ir, 1);
    check_eq("drop_idle", busy, 0);

    // HALT in DECODE: no WB, no count, sticky
    base_ir = ir_cnt; base_pc = pc_cnt;
    dec_halt = 1'b1;
    press_release();
    cyc(1);
    check_eq("halt_fetch", ir_load, 1);
    cyc(1);
    check_eq("halt_decode", {ir_load, mem_write_en, reg_write_en, pc_en, busy}, 5'b00001);
    cyc(1);
    check_eq("halt_state", {halted, busy}, 2'b10);
    dec_halt = 1'b0;
    cyc(3);
    check_eq("halt_no_pc", pc_cnt - base_pc, 0);
    check_eq("halt_count", step_count, 0);
    btnc_db = 1'b1;
    cyc(1);
    check_eq("halt_disp_sel", disp_sel, 1);
    btnc_db = 1'b0;
    cyc(1);
    run_mode = 1'b1;
    cyc(12);
    run_mode = 1'b0;
    cyc(1);
    check_eq("halt_sticky", {halted, busy}, 2'b10);
    check_eq("halt_ignores_input", ir_cnt - base_ir, 1);

    reset = 1'b0;
    cyc(1);
    check_eq("halt_cleared", halted, 0);
    reset = 1'b1;
    cyc(1);

    // Reset in the middle of a step aborts it immediately
    base_pc = pc_cnt;
    press_release();
    cyc(2);
    reset = 1'b0;
    #1;
    check_eq("abort_outputs", {ir_load, mem_write_en, reg_write_en, pc_en, busy}, 0);
    cyc(1);
    reset = 1'b1;
    cyc(6);
    check_eq("abort_no_wb", pc_cnt - base_pc, 0);
    check_eq("abort_count", step_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
